// File: rtl/rob_ring_pkg.sv
// rob_ring_pkg
// Shared types and constants for the reorder buffer slice.
//   ROB_DEPTH   - default number of ROB entries
//   ROB_PREG_W  - physical register index width stored in each entry
//   ROB_DATA_W  - result / operand value width stored in each entry
//   ROB_OPC_W   - opcode width stored in each entry
//   rob_entry_t - one ROB slot (also the retire-port payload)
//   popcount    - number of set bits in a 32-bit vector
package rob_ring_pkg;

    localparam int ROB_DEPTH  = 32;
    localparam int ROB_PREG_W = 6;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_OPC_W  = 7;

    typedef struct packed {
        logic                  in_use;
        logic                  is_complete;
        logic [ROB_PREG_W-1:0] old_preg;
        logic [ROB_PREG_W-1:0] new_preg;
        logic [ROB_OPC_W-1:0]  opcode;
        logic [ROB_DATA_W-1:0] rd_value;
        logic [ROB_DATA_W-1:0] rs1_value;
    } rob_entry_t;

    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_ring_if.sv
// rob_ring_if
// Bundles every ROB-facing signal except clock and reset.
//   master : dispatch, completion and flush drivers; sees status and retire
//   slave  : the ROB itself
// Register and value widths come from rob_ring_pkg so they always match
// the rob_entry_t payload.
interface rob_ring_if
    import rob_ring_pkg::*;
#(
    parameter int DISP_W = 2,
    parameter int CMP_W  = 3,
    parameter int RET_W  = 2,
    parameter int IDX_W  = $clog2(ROB_DEPTH)
);

    logic                                   flush;

    logic [DISP_W-1:0]                      disp_valid;
    logic [DISP_W-1:0][ROB_PREG_W-1:0]      disp_old_preg;
    logic [DISP_W-1:0][ROB_PREG_W-1:0]      disp_new_preg;
    logic                                   disp_ready;
    logic [DISP_W-1:0][IDX_W-1:0]           disp_idx;

    logic [CMP_W-1:0]                       cmp_valid;
    logic [CMP_W-1:0][IDX_W-1:0]            cmp_idx;
    logic [CMP_W-1:0][ROB_OPC_W-1:0]        cmp_opcode;
    logic [CMP_W-1:0][ROB_DATA_W-1:0]       cmp_value;
    logic [CMP_W-1:0][ROB_DATA_W-1:0]       cmp_rs1;

    logic [RET_W-1:0]                       ret_valid;
    rob_entry_t [RET_W-1:0]                 ret_entry;
    logic [$clog2(RET_W+1)-1:0]             num_retired;

    logic [IDX_W:0]                         count;
    logic                                   empty;
    logic                                   full;
    logic                                   stale_cmp;

    modport master (
        output flush, disp_valid, disp_old_preg, disp_new_preg,
        output cmp_valid, cmp_idx, cmp_opcode, cmp_value, cmp_rs1,
        input  disp_ready, disp_idx, ret_valid, ret_entry, num_retired,
        input  count, empty, full, stale_cmp
    );

    modport slave (
        input  flush, disp_valid, disp_old_preg, disp_new_preg,
        input  cmp_valid, cmp_idx, cmp_opcode, cmp_value, cmp_rs1,
        output disp_ready, disp_idx, ret_valid, ret_entry, num_retired,
        output count, empty, full, stale_cmp
    );

endinterface

// File: rtl/rob_ring_retire_sel.sv
// rob_retire_sel
// Picks which of the RET_W oldest entries can retire this cycle.
//   i_head      - oldest entry index
//   i_in_use    - per-entry occupied flags
//   i_complete  - per-entry completed flags
//   o_ret_mask  - lane j set when entries head..head+j are all ready
//   o_ret_cnt   - number of set bits in o_ret_mask
module rob_retire_sel #(
    parameter int DEPTH = 32,
    parameter int RET_W = 2
) (
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [DEPTH-1:0]           i_in_use,
    input  logic [DEPTH-1:0]           i_complete,
    output logic [RET_W-1:0]           o_ret_mask,
    output logic [$clog2(RET_W+1)-1:0] o_ret_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NR_W  = $clog2(RET_W+1);

    // Running AND from the head: one incomplete entry blocks all younger lanes.
    always_comb begin
        logic             w_run;
        logic [IDX_W-1:0] w_idx;
        w_run      = 1'b1;
        w_idx      = '0;
        o_ret_mask = '0;
        o_ret_cnt  = '0;
        for (int j = 0; j < RET_W; j++) begin
            w_idx         = i_head + IDX_W'(j);
            w_run         = w_run & i_in_use[w_idx] & i_complete[w_idx];
            o_ret_mask[j] = w_run;
            if (w_run) begin
                o_ret_cnt = o_ret_cnt + NR_W'(1);
            end
        end
    end

endmodule

// File: rtl/rob_ring.sv
// rob_ring
// Circular in-order-retire reorder buffer.
//   clk    - core clock
//   rst_n  - asynchronous active-low reset
//   bus    - rob_ring_if.slave: dispatch group in, completions in,
//            registered retire lanes out, occupancy/status out
module rob_ring
    import rob_ring_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DISP_W = 2,
    parameter int CMP_W  = 3,
    parameter int RET_W  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    rob_ring_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int NR_W  = $clog2(RET_W+1);

    rob_entry_t                    r_entries [DEPTH];
    logic [IDX_W-1:0]              r_head;
    logic [IDX_W-1:0]              r_tail;
    logic [CNT_W-1:0]              r_count;
    logic [RET_W-1:0]              r_ret_valid;
    rob_entry_t [RET_W-1:0]        r_ret_entry;
    logic [NR_W-1:0]               r_num_retired;
    logic                          r_stale;

    logic [DEPTH-1:0]              w_in_use;
    logic [DEPTH-1:0]              w_complete;
    logic [RET_W-1:0]              w_ret_mask;
    logic [NR_W-1:0]               w_ret_cnt;
    logic [DISP_W-1:0][IDX_W-1:0]  w_disp_idx;
    logic [CNT_W-1:0]              w_disp_cnt;
    logic [CNT_W-1:0]              w_free;
    logic                          w_disp_ready;

    always_comb begin
        w_in_use   = '0;
        w_complete = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_in_use[i]   = r_entries[i].in_use;
            w_complete[i] = r_entries[i].is_complete;
        end
    end

    // Valid lanes are packed: a lane's slot is tail plus the valid lanes below it.
    always_comb begin
        logic [IDX_W-1:0] w_off;
        w_off      = '0;
        w_disp_idx = '0;
        for (int l = 0; l < DISP_W; l++) begin
            w_disp_idx[l] = r_tail + w_off;
            if (bus.disp_valid[l]) begin
                w_off = w_off + IDX_W'(1);
            end
        end
    end

    // Ready depends only on registered count so upstream never sees a loop.
    assign w_disp_cnt   = CNT_W'(popcount(32'(bus.disp_valid)));
    assign w_free       = CNT_W'(DEPTH) - r_count;
    assign w_disp_ready = (w_free >= CNT_W'(DISP_W));

    rob_retire_sel #(
        .DEPTH (DEPTH),
        .RET_W (RET_W)
    ) u_retire_sel (
        .i_head     (r_head),
        .i_in_use   (w_in_use),
        .i_complete (w_complete),
        .o_ret_mask (w_ret_mask),
        .o_ret_cnt  (w_ret_cnt)
    );

    // Dispatch only touches free slots and retire only touches occupied ones,
    // and completion checks the registered in_use, so the three writers never
    // collide on a field within one edge. A completion aimed at a slot being
    // dispatched this edge sees in_use=0 and is flagged stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_ret_valid   <= '0;
            r_ret_entry   <= '0;
            r_num_retired <= '0;
            r_stale       <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].in_use      <= 1'b0;
                r_entries[i].is_complete <= 1'b0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_ret_valid   <= '0;
            r_num_retired <= '0;
        end else begin
            if (w_disp_ready) begin
                for (int l = 0; l < DISP_W; l++) begin
                    if (bus.disp_valid[l]) begin
                        r_entries[w_disp_idx[l]].in_use      <= 1'b1;
                        r_entries[w_disp_idx[l]].is_complete <= 1'b0;
                        r_entries[w_disp_idx[l]].old_preg    <= bus.disp_old_preg[l];
                        r_entries[w_disp_idx[l]].new_preg    <= bus.disp_new_preg[l];
                        r_entries[w_disp_idx[l]].opcode      <= '0;
                        r_entries[w_disp_idx[l]].rd_value    <= '0;
                        r_entries[w_disp_idx[l]].rs1_value   <= '0;
                    end
                end
                r_tail <= r_tail + w_disp_cnt[IDX_W-1:0];
            end

            // Later lanes overwrite earlier ones, so the highest lane wins.
            for (int c = 0; c < CMP_W; c++) begin
                if (bus.cmp_valid[c]) begin
                    if (r_entries[bus.cmp_idx[c]].in_use) begin
                        r_entries[bus.cmp_idx[c]].is_complete <= 1'b1;
                        r_entries[bus.cmp_idx[c]].opcode      <= bus.cmp_opcode[c];
                        r_entries[bus.cmp_idx[c]].rd_value    <= bus.cmp_value[c];
                        r_entries[bus.cmp_idx[c]].rs1_value   <= bus.cmp_rs1[c];
                    end else begin
                        r_stale <= 1'b1;
                    end
                end
            end

            // Non-retiring lanes keep their last payload; only valid drops.
            for (int j = 0; j < RET_W; j++) begin
                r_ret_valid[j] <= w_ret_mask[j];
                if (w_ret_mask[j]) begin
                    r_ret_entry[j] <= r_entries[r_head + IDX_W'(j)];
                    r_entries[r_head + IDX_W'(j)].in_use      <= 1'b0;
                    r_entries[r_head + IDX_W'(j)].is_complete <= 1'b0;
                end
            end

            r_head        <= r_head + IDX_W'(w_ret_cnt);
            r_count       <= r_count + (w_disp_ready ? w_disp_cnt : '0) - CNT_W'(w_ret_cnt);
            r_num_retired <= w_ret_cnt;
        end
    end

    assign bus.disp_ready  = w_disp_ready;
    assign bus.disp_idx    = w_disp_idx;
    assign bus.ret_valid   = r_ret_valid;
    assign bus.ret_entry   = r_ret_entry;
    assign bus.num_retired = r_num_retired;
    assign bus.count       = r_count;
    assign bus.empty       = (r_count == '0);
    assign bus.full        = (r_count == CNT_W'(DEPTH));
    assign bus.stale_cmp   = r_stale;

endmodule

// File: doc/rob_ring.md
Name: rob_ring

Overview:
- Parametrised in-order-retire reorder buffer for the out-of-order core.
- Sits between rename/dispatch, which allocates entries, and the functional units, which report completion. Also sits before the free-list/commit stage, which consumes retired entries.
- Generalises the fixed 32-entry, 2-dispatch, 3-completion ROB: configurable depth and port widths, backpressure (full/ready), occupancy count, flush, and stale-completion detection.

Parameters:
- DEPTH, 32, number of entries; power of two, >= 4
- DISP_W, 2, dispatch lanes per cycle
- CMP_W, 3, completion ports (one per functional unit)
- RET_W, 2, maximum retirements per cycle
- PREG_W, 6, physical register index width
- DATA_W, 32, result value width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries
- disp_valid  in  DISP_W  per-lane dispatch request
- disp_old_preg  in  DISP_W*PREG_W  previous mapping of dest reg
- disp_new_preg  in  DISP_W*PREG_W  newly allocated dest preg
- disp_ready  out  1  ROB can accept a full dispatch group this cycle
- disp_idx  out  DISP_W*IDX_W  index assigned to each valid lane (combinational)
- cmp_valid  in  CMP_W  functional-unit result valid
- cmp_idx  in  CMP_W*IDX_W  target ROB index
- cmp_opcode  in  CMP_W*7  instruction opcode
- cmp_value  in  CMP_W*DATA_W  result value
- cmp_rs1  in  CMP_W*DATA_W  source-1 operand value
- ret_valid  out  RET_W  retire lane valid; lanes are contiguous from lane 0
- ret_entry  out  RET_W*rob_entry_t  retired entry contents
- num_retired  out  $clog2(RET_W+1)  count of set ret_valid bits
- count  out  IDX_W+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- stale_cmp  out  1  sticky: a completion targeted an entry that is not in use

Behaviour:
- IDX_W = $clog2(DEPTH).
- head and tail are IDX_W-bit pointers and wrap naturally modulo DEPTH.
- Reset (async assert, sync release):
  - head = tail = 0, count = 0.
  - All entries have in_use = 0 and is_complete = 0.
  - ret_valid = 0, ret_entry = 0, num_retired = 0, stale_cmp = 0.
  - Derived outputs: empty = 1, full = 0, disp_ready = 1.
- Dispatch:
  - disp_ready = (DEPTH - count) >= DISP_W. It is combinational from registered state only.
  - A group is accepted at posedge only when disp_ready is 1. If disp_ready is 0, the whole group is dropped and upstream holds it.
  - Valid lanes are packed in lane order: the k-th valid lane gets index tail+k, and disp_idx reflects this.
  - On acceptance, tail advances by popcount(disp_valid).
  - New entry state: in_use=1, is_complete=0, old/new preg from the lane, value/opcode/rs1 = 0.
- Completion:
  - Applied at posedge for each cmp_valid lane.
  - If entry[cmp_idx].in_use=1, set is_complete=1 and write opcode, value and rs1.
  - If in_use=0 (including a slot being dispatched this same edge), ignore the write and set stale_cmp. stale_cmp clears only on reset.
  - If two lanes target the same index in one cycle, the highest-numbered lane wins.
- Retire:
  - Evaluated on registered state at posedge.
  - Lane j retires entry head+j iff entries head..head+j are all in_use and is_complete, and j < RET_W. Retirement stops at the first incomplete entry.
  - Retired entries get in_use=0 and is_complete=0. head advances by the number retired.
  - ret_valid, ret_entry and num_retired are registered. Lanes not retiring this cycle drive ret_valid=0, and their ret_entry holds its previous value.
- Latency: completion written at edge N → earliest ret_valid is high after edge N+1.
- Simultaneous events:
  - count_next = count + dispatched - retired.
  - Dispatch and retire in the same cycle with count == DEPTH is legal: dispatch is blocked by disp_ready and retire still proceeds.
- Flush:
  - Highest priority. At posedge with flush=1, head = tail = 0, count = 0, and all in_use/is_complete are cleared.
  - Same-cycle dispatch, completion and retire are discarded; ret_valid=0 next cycle.
  - stale_cmp is unaffected by flush.
- Wrap-around: dispatch groups and retire windows span index DEPTH-1→0 seamlessly.

Decomposition:
- my_package:
  - rob_entry_t packed struct: in_use, is_complete, old_preg, new_preg, opcode, rd_value, rs1_value.
  - ROB_DEPTH default constant.
  - A popcount helper function.
- Sub-module rob_retire_sel: combinational, RET_W-wide prefix-AND of in_use&is_complete over head..head+RET_W-1. Produces ret_mask and the retire count.

Test Plan (DEPTH=8, DISP_W=2, CMP_W=3, RET_W=2):
- Reset, then dispatch 4 cycles of 2 lanes (new_preg 32..39) → count=8, full=1, disp_ready=0; a 5th group is dropped and tail stays 0.
- With count=8, complete idx 0,1 at edge N → after N+1: ret_valid=2'b11, entries' new_preg=32,33, count=6, disp_ready=1.
- Complete idx 2 and 4 (not 3) → only idx 2 retires (num_retired=1). Complete idx 3 → next cycle idx 3,4 retire together.
- Wrap: head=6, dispatch 2 lanes → disp_idx=6,7; next group gets 0,1. Completing 6,7 retires them and head=0.
- cmp_valid on an idx with in_use=0 → stale_cmp=1 and the entry is unchanged. Two lanes writing idx 5 with values 0xA and 0xB → the retired value is 0xB.
- flush asserted with 5 entries, a completion and a dispatch all in the same cycle → next cycle count=0, empty=1, ret_valid=0, disp_idx lane0=0.
